// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div over a fixed
// number of busy cycles, handles mthi/mtlo in one cycle, and raises the D-stage MD stall.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_start,
  input  logic [2:0]       c_mdop,
  input  logic [WIDTH-1:0] v_A,
  input  logic [WIDTH-1:0] v_B,
  input  logic             c_selHI,
  input  logic             c_MD_D,
  output logic             c_busy,
  output logic [WIDTH-1:0] v_HI,
  output logic [WIDTH-1:0] v_LO,
  output logic [WIDTH-1:0] v_MDout,
  output logic             h_stall_MD
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int W2      = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic             p_wr;

  logic             start_multi;
  logic             accept;
  logic             commit;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  // Signed divide returning {remainder, quotient}; INT_MIN / -1 is pinned to
  // {0, INT_MIN} so the overflow case never depends on simulator semantics.
  function automatic logic [W2-1:0] div_signed(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if ((a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
      q = a;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [W2-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] bs;
    bs = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    return {a % bs, a / bs};
  endfunction

  logic signed [W2-1:0] sa_x, sb_x, prod_s;
  logic        [W2-1:0] ua_x, ub_x, prod_u;
  logic        [W2-1:0] quot_s, quot_u;

  assign sa_x   = {{WIDTH{v_A[WIDTH-1]}}, v_A};
  assign sb_x   = {{WIDTH{v_B[WIDTH-1]}}, v_B};
  assign prod_s = sa_x * sb_x;
  assign ua_x   = {{WIDTH{1'b0}}, v_A};
  assign ub_x   = {{WIDTH{1'b0}}, v_B};
  assign prod_u = ua_x * ub_x;
  assign quot_s = div_signed(v_A, v_B);
  assign quot_u = div_unsigned(v_A, v_B);

  assign start_multi = c_start && (c_mdop >= OP_MULT) && (c_mdop <= OP_DIVU);
  assign accept      = (state == IDLE) && c_start;
  assign commit      = (state == BUSY) && (cnt == CNT_W'(1));

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    case (c_mdop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = quot_s;
      OP_DIVU:  {res_hi, res_lo} = quot_u;
      default:  res_wr = 1'b0;
    endcase
    if ((c_mdop == OP_DIV || c_mdop == OP_DIVU) && v_B == '0) res_wr = 1'b0;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start_multi) begin
          state_next = BUSY;
          cnt_next   = (c_mdop <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Pending result: captured at start, held until the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_wr <= 1'b0;
    end else if (accept && start_multi) begin
      p_wr <= res_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && start_multi) begin
      p_hi <= res_hi;
      p_lo <= res_lo;
    end
  end

  // Architectural HI/LO: commit of a finished op, or a single-cycle move.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (p_wr) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end else if (accept && c_mdop == OP_MTHI) begin
      hi <= v_A;
    end else if (accept && c_mdop == OP_MTLO) begin
      lo <= v_A;
    end
  end

  assign c_busy     = (state == BUSY);
  assign v_HI       = hi;
  assign v_LO       = lo;
  assign v_MDout    = c_selHI ? hi : lo;
  assign h_stall_MD = c_MD_D && (c_busy || start_multi);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed and random MD ops against a 64-bit arithmetic
// reference of HI/LO, busy duration and the D-stage stall.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_start;
  logic [2:0]  c_mdop;
  logic [31:0] v_A, v_B;
  logic        c_selHI;
  logic        c_MD_D;
  logic        c_busy;
  logic [31:0] v_HI, v_LO, v_MDout;
  logic        h_stall_MD;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .c_start(c_start), .c_mdop(c_mdop),
    .v_A(v_A), .v_B(v_B), .c_selHI(c_selHI), .c_MD_D(c_MD_D),
    .c_busy(c_busy), .v_HI(v_HI), .v_LO(v_LO), .v_MDout(v_MDout),
    .h_stall_MD(h_stall_MD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: what MIPS says HI/LO become after the op.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd1: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
      3'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_multi(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic md_d, input logic inject_mt);
    int n;
    int nb;
    logic [31:0] old_hi, old_lo;
    n = (op <= 3'd2) ? 5 : 10;
    nb = 0;
    old_hi = m_hi;
    old_lo = m_lo;
    c_start = 1'b1; c_mdop = op; v_A = a; v_B = b; c_MD_D = md_d;
    #1;
    chk("stall_start", {31'h0, h_stall_MD}, {31'h0, md_d});
    chk("busy_start", {31'h0, c_busy}, 32'h0);
    next_cycle();
    while (c_busy === 1'b1 && nb < 40) begin
      nb++;
      c_start = inject_mt && (nb == 2);
      c_mdop  = (inject_mt && nb == 2) ? 3'd6 : 3'd0;
      v_A = $urandom; v_B = $urandom;
      #1;
      chk("stall_busy", {31'h0, h_stall_MD}, {31'h0, md_d});
      chk("hi_hidden", v_HI, old_hi);
      chk("lo_hidden", v_LO, old_lo);
      next_cycle();
    end
    c_start = 1'b0; c_mdop = 3'd0;
    #1;
    chk("busy_len", 32'(nb), 32'(n));
    model_op(op, a, b);
    chk("hi_commit", v_HI, m_hi);
    chk("lo_commit", v_LO, m_lo);
    chk("stall_after", {31'h0, h_stall_MD}, 32'h0);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    c_start = 1'b1; c_mdop = op; v_A = a;
    #1;
    next_cycle();
    c_start = 1'b0; c_mdop = 3'd0;
    #1;
    model_op(op, a, 32'h0);
    chk("mt_busy", {31'h0, c_busy}, 32'h0);
    chk("mt_hi", v_HI, m_hi);
    chk("mt_lo", v_LO, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; c_start = 1'b0; c_mdop = 3'd0; v_A = 0; v_B = 0;
    c_selHI = 1'b0; c_MD_D = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst_busy", {31'h0, c_busy}, 32'h0);
    chk("rst_hi", v_HI, 32'h0);
    chk("rst_lo", v_LO, 32'h0);
    chk("rst_mdout", v_MDout, 32'h0);
    reset = 1'b0;

    run_multi(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    chk("mult_hi_k", v_HI, 32'hFFFFFFFF);
    chk("mult_lo_k", v_LO, 32'hFFFFFFFA);
    run_multi(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("multu_hi_k", v_HI, 32'h00000002);
    chk("multu_lo_k", v_LO, 32'hFFFFFFFA);
    run_multi(3'd3, -32'sd7, 32'd2, 1'b0, 1'b0);
    chk("div_lo_k", v_LO, 32'hFFFFFFFD);
    chk("div_hi_k", v_HI, 32'hFFFFFFFF);
    run_multi(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_lo_k", v_LO, 32'd3);
    chk("divu_hi_k", v_HI, 32'd1);
    run_multi(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("ovf_lo_k", v_LO, 32'h80000000);
    chk("ovf_hi_k", v_HI, 32'h0);
    mt(3'd5, 32'h11);
    mt(3'd6, 32'h22);
    run_multi(3'd4, 32'h1234, 32'h0, 1'b0, 1'b0);
    chk("dz_hi_k", v_HI, 32'h11);
    chk("dz_lo_k", v_LO, 32'h22);

    // Consecutive MTHI then MTLO, with v_MDout following c_selHI.
    c_start = 1'b1; c_mdop = 3'd5; v_A = 32'hDEADBEEF;
    next_cycle();
    c_mdop = 3'd6; v_A = 32'h12345678; c_selHI = 1'b1;
    #1;
    chk("mthi_vis", v_HI, 32'hDEADBEEF);
    chk("mthi_busy", {31'h0, c_busy}, 32'h0);
    chk("mdout_hi", v_MDout, 32'hDEADBEEF);
    next_cycle();
    c_start = 1'b0; c_mdop = 3'd0; c_selHI = 1'b0;
    #1;
    chk("mtlo_vis", v_LO, 32'h12345678);
    chk("mtlo_busy", {31'h0, c_busy}, 32'h0);
    chk("mdout_lo", v_MDout, 32'h12345678);
    m_hi = 32'hDEADBEEF; m_lo = 32'h12345678;

    // Stall window plus an MTLO issued mid-operation that must be ignored.
    run_multi(3'd1, 32'd6, 32'd7, 1'b1, 1'b1);
    chk("mt_ignored_lo", v_LO, 32'd42);
    c_MD_D = 1'b0;

    // Reset in the third busy cycle of a DIV.
    c_start = 1'b1; c_mdop = 3'd3; v_A = 32'd100; v_B = 32'd7;
    next_cycle();
    c_start = 1'b0; c_mdop = 3'd0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rstmid_busy", {31'h0, c_busy}, 32'h0);
    chk("rstmid_hi", v_HI, 32'h0);
    chk("rstmid_lo", v_LO, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      chk("rstmid_nobusy", {31'h0, c_busy}, 32'h0);
    end
    chk("rstmid_hi_late", v_HI, 32'h0);
    chk("rstmid_lo_late", v_LO, 32'h0);

    // Random ops, back to back.
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (op <= 3'd4) run_multi(op, a, b, 1'($urandom), 1'($urandom));
      else mt(op, a);
      c_selHI = 1'($urandom);
      #1;
      chk("rand_mdout", v_MDout, c_selHI ? m_hi : m_lo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
